divider_seq_4bit: RTL and testbench



---
 rtl/divider_seq_4bit_pkg.sv | 17 +
 rtl/divider_seq_4bit_div_step.sv | 30 +++
 rtl/divider_seq_4bit.sv | 114 +++++++++++
 tb/tb_divider_seq_4bit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_seq_4bit_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; floor of 1 bit keeps the smallest legal WIDTH synthesizable.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_seq_4bit_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract divisor, restore on borrow.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // R stays below the divisor, so the WIDTH+1-bit trial never wraps and its MSB is the sign.
  always_comb begin
    shifted = {r_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      r_out = trial[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = shifted[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_seq_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, done pulse with held results.
module divider_seq_4bit
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] a_q;
  logic [CNT_W-1:0] cnt;
  logic             zero_pend;

  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;

  logic accept;
  logic last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (d_q),
    .r_out   (step_r),
    .q_out   (step_q)
  );

  // A zero divisor spends one IDLE cycle with zero_pend set so DONE lands one edge after accept.
  assign accept    = (state == IDLE) && !zero_pend && start;
  assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (zero_pend) begin
          state_next = DONE;
        end else if (start && (divisor != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_q         <= dividend;
      d_q         <= divisor;
      r_q         <= '0;
      q_q         <= dividend;
      cnt         <= '0;
      zero_pend   <= (divisor == '0);
      div_by_zero <= 1'b0;
    end else if (zero_pend) begin
      zero_pend   <= 1'b0;
      quotient    <= '1;
      remainder   <= a_q;
      div_by_zero <= 1'b1;
    end else if (state == RUN) begin
      r_q <= step_r;
      q_q <= step_q;
      cnt <= cnt + CNT_W'(1);
      if (last_step) begin
        quotient  <= step_q;
        remainder <= step_r;
      end
    end
  end

endmodule

// File: tb/tb_divider_seq_4bit.sv
// Directed and exhaustive checks for divider_seq_4bit (WIDTH=4).
module tb_divider_seq_4bit;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divider_seq_4bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           busy_n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one start pulse; returns right after the accept edge (+1).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after accept until done (bounded), then confirm the pulse lasts one cycle.
  task automatic wait_done(output int lat, output int busy_n, output logic [W-1:0] q,
                           output logic [W-1:0] r, output logic dz);
    lat    = 0;
    busy_n = busy ? 1 : 0;
    q      = '0;
    r      = '0;
    dz     = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("done_single_cycle", int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, busy_n, seen, mask;
    logic [W-1:0] q, r;
    logic         dz;

    vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 4, 4};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, 4};
    vecs[2] = '{4'd5,  4'd7, 4'd0,  4'd5, 1'b0, 4, 4};
    vecs[3] = '{4'd0,  4'd9, 4'd0,  4'd0, 1'b0, 4, 4};
    vecs[4] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1, 0};
    vecs[5] = '{4'd12, 4'd5, 4'd2,  4'd2, 1'b0, 4, 4};
    vecs[6] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, 4};
    vecs[7] = '{4'd14, 4'd4, 4'd3,  4'd2, 1'b0, 4, 4};
    vecs[8] = '{4'd1,  4'd15, 4'd0, 4'd1, 1'b0, 4, 4};
    vecs[9] = '{4'd0,  4'd0, 4'd15, 4'd0, 1'b1, 1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, busy_n, q, r, dz);
      chk($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
      chk($sformatf("vec%0d_div_by_zero", i), int'(dz), int'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].busy_n);
    end

    // div_by_zero clears at accept while quotient holds until the new result
    launch(4'd9, 4'd0);
    wait_done(lat, busy_n, q, r, dz);
    launch(4'd6, 4'd3);
    chk("dz_clear_on_accept", int'(div_by_zero), 0);
    chk("quotient_held_after_accept", int'(quotient), 15);
    wait_done(lat, busy_n, q, r, dz);
    chk("after_dz_quotient", int'(q), 2);
    chk("after_dz_remainder", int'(r), 0);

    // start with new operands mid-RUN is ignored
    launch(4'd14, 4'd4);
    @(posedge clk);
    #1;
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        break;
      end
    end
    chk("midrun_start_latency", lat, 4);
    chk("midrun_start_quotient", int'(q), 3);
    chk("midrun_start_remainder", int'(r), 2);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midrun_start_not_queued", seen, 0);

    // Reset mid-RUN discards the operation
    launch(4'd13, 4'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_div_by_zero", int'(div_by_zero), 0);
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    launch(4'd12, 4'd5);
    wait_done(lat, busy_n, q, r, dz);
    chk("post_rst_quotient", int'(q), 2);
    chk("post_rst_remainder", int'(r), 2);
    chk("post_rst_latency", lat, 4);

    // start held high restarts at edge WIDTH+2: done after edges 4 and 10
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    mask     = 0;
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (done) mask |= (1 << k);
    end
    start = 1'b0;
    chk("held_start_done_mask", mask, (1 << 4) | (1 << 10));
    chk("held_start_quotient", int'(quotient), 3);
    chk("held_start_remainder", int'(remainder), 1);
    repeat (2) @(posedge clk);

    // Exhaustive operand pairs, back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int  prod;
        bit  ok;
        launch(4'(a), 4'(b));
        wait_done(lat, busy_n, q, r, dz);
        prod = int'(q) * b + int'(r);
        if (b == 0)
          ok = (lat == 1) && (busy_n == 0) && (q == 4'hF) && (int'(r) == a) && dz;
        else
          ok = (lat == 4) && (busy_n == 4) && (prod == a) && (int'(r) < b) && !dz;
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL exhaustive %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d busy=%0d",
                   a, b, q, r, dz, lat, busy_n);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
